// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active low.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // All segments dark
  localparam seg_t SEG_OFF = 7'h7F;

  // Hex glyphs 0..F, indexed by nibble value
  localparam seg_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg_c
);

  // Table lookup of the glyph for the selected nibble
  always_comb begin
    seg_c = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// Double-buffered value/enable/dp sets are swapped only on frame boundaries.
// Optional leading-zero blanking is built when SEG7_LZB_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * DIGITS;

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              tick;
  logic              wrap;

  logic [VAL_W-1:0]  pend_value;
  logic [DIGITS-1:0] pend_en;
  logic [DIGITS-1:0] pend_dp;
  logic              pend_valid;

  logic [VAL_W-1:0]  act_value;
  logic [DIGITS-1:0] act_en;
  logic [DIGITS-1:0] act_dp;

  logic [DIGITS-1:0] lz_mask;
  logic [DIGITS-1:0] an_sel;
  logic [3:0]        cur_nib;
  logic              cur_en;
  logic              cur_dp;
  logic              cur_lz;
  logic              cur_show;
  seg_t              dec_seg;

  assign tick = (cnt == CNT_W'(CLK_DIV - 1));
  assign wrap = tick && (idx == IDX_W'(DIGITS - 1));

  // Prescaler and digit index; the index wraps on the last digit's tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Pending/active shadow sets; a load in the boundary cycle bypasses pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_value <= '0;
      pend_en    <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      act_value  <= '0;
      act_en     <= '0;
      act_dp     <= '0;
    end else if (wrap) begin
      pend_valid <= 1'b0;
      if (load) begin
        act_value <= value;
        act_en    <= digit_en;
        act_dp    <= dp;
      end else if (pend_valid) begin
        act_value <= pend_value;
        act_en    <= pend_en;
        act_dp    <= pend_dp;
      end
    end else if (load) begin
      pend_value <= value;
      pend_en    <= digit_en;
      pend_dp    <= dp;
      pend_valid <= 1'b1;
    end
  end

`ifdef SEG7_LZB_EN
  // Leading-zero mask: digit i>0 dark while it and every higher enabled digit is zero
  always_comb begin : lzb_calc
    logic zero_above;
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above & ~(act_en[i] & (|act_value[4*i +: 4]));
      if (i > 0) begin
        lz_mask[i] = zero_above;
      end
    end
  end
`else
  // Without leading-zero blanking only digit_en darkens a digit
  always_comb begin
    lz_mask = '0;
  end
`endif

  // Select the current digit's attributes and its one-hot anode
  always_comb begin
    cur_nib = '0;
    cur_en  = 1'b0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    an_sel  = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = act_value[4*i +: 4];
        cur_en    = act_en[i];
        cur_dp    = act_dp[i];
        cur_lz    = lz_mask[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  assign cur_show = cur_en & ~cur_lz;

  seg7_hex_dec u_dec (
    .nibble (cur_nib),
    .seg_c  (dec_seg)
  );

  // Registered pin drive; anodes are dark for the first cycle of each slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_OFF;
      dp_n       <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= cur_show ? dec_seg : SEG_OFF;
      dp_n       <= ~(cur_dp & cur_show);
      an         <= (cnt == '0) ? '1 : an_sel;
      frame_done <= wrap;
    end
  end

endmodule
